samp_timing: RTL and testbench
==============================

SAMP_TIMING -- requirements
Module: samp_timing

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the period and width counters.
REQ-002 SHALL have parameter DEF_PERIOD, default 16: period in clk cycles applied at reset.
REQ-003 SHALL have parameter DEF_WIDTH, default 4: sampling-window width in clk cycles applied at reset.
REQ-004 SHALL have port clk  input  1: single clock; all flops clocked on its rising edge.
REQ-005 SHALL have port rst_b  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port en  input  1: run request for continuous framing.
REQ-007 SHALL have port period  input  CNT_W: requested frame length in cycles.
REQ-008 SHALL have port samp_width  input  CNT_W: requested samp_clk high time in cycles.
REQ-009 SHALL have port cfg_load  input  1: one-cycle strobe that captures period and samp_width.
REQ-010 SHALL have port samp_clk  output  1: sampling clock, driven directly from a flop; feeds the sampling clock driver input.
REQ-011 SHALL have port conv_start  output  1: one-cycle pulse on the first conversion cycle of each frame.
REQ-012 SHALL have port busy  output  1: high whenever the FSM is not IDLE.
REQ-013 SHALL have port cfg_err  output  1: sticky flag for a rejected configuration.

Function
REQ-014 SHALL implement the FSM states IDLE, SAMPLE and CONVERT; samp_clk SHALL be 1 only in SAMPLE.
REQ-015 SHALL go IDLE->SAMPLE on the cycle after en is sampled high, with the frame counter reset to 0.
REQ-016 SHALL hold SAMPLE for exactly width_act cycles, then CONVERT for period_act-width_act cycles.
REQ-017 SHALL assert conv_start only in the first CONVERT cycle of each frame.
REQ-018 SHALL, at the last CONVERT cycle, go to SAMPLE if en=1, otherwise to IDLE.
REQ-019 SHALL complete the current frame when en deasserts mid-frame; samp_clk high time SHALL never be truncated.
REQ-020 SHALL treat a cfg_load as valid only when samp_width>=1, period>=2 and samp_width<period.
REQ-021 SHALL set cfg_err and leave the active configuration unchanged when cfg_load is invalid.
REQ-022 SHALL clear cfg_err on a valid cfg_load.
REQ-023 SHALL copy a valid load into period_act/width_act on the next cycle when in IDLE.
REQ-024 SHALL, outside IDLE, store a valid load in a shadow register with a pending flag and apply it at the next frame boundary.
REQ-025 SHALL make a load in the last cycle of a frame effective for the immediately following frame.
REQ-026 SHALL let the newest load override an earlier pending one; an invalid load SHALL NOT clear a pending valid load.
REQ-027 SHALL use unsigned arithmetic of CNT_W bits for the counter, which SHALL never wrap because of the REQ-020 limits.

Reset
REQ-028 SHALL, while rst_b=0, force state=IDLE, counter=0, samp_clk=0, conv_start=0, busy=0, cfg_err=0 and pending=0.
REQ-029 SHALL, while rst_b=0, force period_act=DEF_PERIOD and width_act=DEF_WIDTH.
REQ-030 SHALL drop samp_clk to 0 immediately on a reset asserted mid-frame, with no completion of the frame.
REQ-031 SHALL leave the first cycle after reset release in IDLE.

Configuration
REQ-032 SHALL, when SAMP_BURST_EN is defined, add port burst_len  input  CNT_W and port burst_done  output  1 (reset 0).
REQ-033 SHALL, with SAMP_BURST_EN and burst_len=N>0, run N frames and then enter IDLE even if en=1.
REQ-034 SHALL, with SAMP_BURST_EN, pulse burst_done for one cycle on entry to IDLE after a completed burst.
REQ-035 SHALL, with SAMP_BURST_EN, require en to go low and then high to start a new burst; burst_len=0 SHALL mean continuous.
REQ-036 SHALL, without SAMP_BURST_EN, omit the burst ports and logic and always run continuous framing.

Verification
REQ-037 SHALL cover: reset defaults, en=1 at cycle 0 -> samp_clk high cycles 1-4, conv_start at cycle 5, next samp_clk rise at cycle 17.
REQ-038 SHALL cover: cfg_load period=10 width=3 mid-frame -> current frame stays 16/4, next frame has samp_clk 3 cycles and frame 10 cycles.
REQ-039 SHALL cover: cfg_load period=5 width=5 -> cfg_err=1, timing unchanged; then period=6 width=2 -> cfg_err=0.
REQ-040 SHALL cover: en dropped during SAMPLE cycle 2 -> full 4-cycle window, frame completes, then busy=0.
REQ-041 SHALL cover: rst_b low during SAMPLE -> samp_clk=0 asynchronously, and all REQ-028/029 values restored.
REQ-042 SHALL cover, with SAMP_BURST_EN: burst_len=3, en held high -> exactly 3 samp_clk pulses, burst_done one cycle, busy=0.

Source files
------------

// File: rtl/samp_timing.sv
// samp_timing: sampling-clock / conversion-start frame generator.
// Each frame is a SAMPLE window (samp_clk high for width_act cycles)
// followed by a CONVERT phase whose first cycle pulses conv_start.
// Optional feature macro: SAMP_BURST_EN adds burst_len/burst_done and
// stops framing after burst_len frames (0 = continuous).
module samp_timing #(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 16,
    parameter int DEF_WIDTH  = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] samp_width,
    input  logic             cfg_load,
`ifdef SAMP_BURST_EN
    input  logic [CNT_W-1:0] burst_len,
    output logic             burst_done,
`endif
    output logic             samp_clk,
    output logic             conv_start,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEF_WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] width_act_q, width_act_d;
    logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
    logic [CNT_W-1:0] shadow_width_q, shadow_width_d;
    logic             pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;
    logic             samp_clk_q, samp_clk_d;
    logic             conv_start_q, conv_start_d;

    logic cfg_valid;
    logic frame_start;
    logic frame_end;
    logic burst_stop;
    logic start_ok;

    // A load is only accepted if the window fits strictly inside the frame.
    assign cfg_valid = cfg_load && (samp_width != '0) && (period > ONE) &&
                       (samp_width < period);
    assign frame_start = (state_q == IDLE) && en && start_ok;
    assign frame_end   = (state_q == CONVERT) && (cnt_q == period_act_q - ONE);

`ifdef SAMP_BURST_EN
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] burst_len_q, burst_len_d;
    logic             burst_lock_q, burst_lock_d;
    logic             burst_done_q, burst_done_d;

    assign burst_stop = (burst_len_q != '0) && (burst_cnt_q + ONE == burst_len_q);
    assign start_ok   = !burst_lock_q;
    assign burst_done = burst_done_q;

    // Burst bookkeeping: count finished frames, lock out restart until en drops.
    always_comb begin
        burst_cnt_d  = burst_cnt_q;
        burst_len_d  = burst_len_q;
        burst_lock_d = burst_lock_q;
        burst_done_d = 1'b0;
        if (!en) begin
            burst_lock_d = 1'b0;
        end
        if (frame_start) begin
            burst_cnt_d = '0;
            burst_len_d = burst_len;
        end else if (frame_end && (burst_len_q != '0)) begin
            if (burst_stop) begin
                burst_cnt_d  = '0;
                burst_done_d = 1'b1;
                burst_lock_d = 1'b1;
            end else begin
                burst_cnt_d = burst_cnt_q + ONE;
            end
        end
    end

    // Burst registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            burst_cnt_q  <= '0;
            burst_len_q  <= '0;
            burst_lock_q <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            burst_cnt_q  <= burst_cnt_d;
            burst_len_q  <= burst_len_d;
            burst_lock_q <= burst_lock_d;
            burst_done_q <= burst_done_d;
        end
    end
`else
    assign burst_stop = 1'b0;
    assign start_ok   = 1'b1;
`endif

    // Frame FSM, counter and configuration handover; outputs are pre-registered.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        conv_start_d    = 1'b0;
        period_act_d    = period_act_q;
        width_act_d     = width_act_q;
        shadow_period_d = shadow_period_q;
        shadow_width_d  = shadow_width_q;
        pending_d       = pending_q;
        cfg_err_d       = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == width_act_q - ONE) begin
                    state_d      = CONVERT;
                    conv_start_d = 1'b1;
                end
            end
            CONVERT: begin
                if (frame_end) begin
                    cnt_d   = '0;
                    state_d = (en && !burst_stop) ? SAMPLE : IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // New timing only ever lands between frames, so a running window is never cut.
        if (cfg_load) begin
            cfg_err_d = !cfg_valid;
        end
        if (cfg_valid) begin
            if ((state_q == IDLE) || frame_end) begin
                period_act_d = period;
                width_act_d  = samp_width;
                pending_d    = 1'b0;
            end else begin
                shadow_period_d = period;
                shadow_width_d  = samp_width;
                pending_d       = 1'b1;
            end
        end else if (frame_end && pending_q) begin
            period_act_d = shadow_period_q;
            width_act_d  = shadow_width_q;
            pending_d    = 1'b0;
        end

        samp_clk_d = (state_d == SAMPLE);
    end

    // State and configuration registers; reset returns to the default timing.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            period_act_q    <= DEF_P;
            width_act_q     <= DEF_W;
            shadow_period_q <= DEF_P;
            shadow_width_q  <= DEF_W;
            pending_q       <= 1'b0;
            cfg_err_q       <= 1'b0;
            samp_clk_q      <= 1'b0;
            conv_start_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            period_act_q    <= period_act_d;
            width_act_q     <= width_act_d;
            shadow_period_q <= shadow_period_d;
            shadow_width_q  <= shadow_width_d;
            pending_q       <= pending_d;
            cfg_err_q       <= cfg_err_d;
            samp_clk_q      <= samp_clk_d;
            conv_start_q    <= conv_start_d;
        end
    end

    assign samp_clk   = samp_clk_q;
    assign conv_start = conv_start_q;
    assign busy       = (state_q != IDLE);
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_samp_timing.sv
// Directed testbench for samp_timing with hand-computed frame timing.
module tb_samp_timing;

    logic       clk;
    logic       rst_b;
    logic       en;
    logic [7:0] period;
    logic [7:0] samp_width;
    logic       cfg_load;
    logic       samp_clk;
    logic       conv_start;
    logic       busy;
    logic       cfg_err;
`ifdef SAMP_BURST_EN
    logic [7:0] burst_len;
    logic       burst_done;
`endif

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    // Frame table for the continuous run: start cycle and window width.
    int fs [9] = '{1, 17, 33, 43, 53, 63, 73, 79, 85};
    int fw [9] = '{4, 4, 3, 3, 3, 3, 2, 2, 1};

    samp_timing dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .en         (en),
        .period     (period),
        .samp_width (samp_width),
        .cfg_load   (cfg_load),
`ifdef SAMP_BURST_EN
        .burst_len  (burst_len),
        .burst_done (burst_done),
`endif
        .samp_clk   (samp_clk),
        .conv_start (conv_start),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_samp(input int c);
        for (int i = 0; i < 9; i++) begin
            if (c >= fs[i] && c < fs[i] + fw[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_conv(input int c);
        for (int i = 0; i < 9; i++) begin
            if (c == fs[i] + fw[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic load_v, input logic [7:0] p, input logic [7:0] w);
        cfg_load   = load_v;
        period     = p;
        samp_width = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
    endtask

    initial begin
        rst_b = 1'b0;
        en    = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0);
`ifdef SAMP_BURST_EN
        burst_len = 8'd0;
`endif
        step();
        step();
        checkOutput("rst_samp_clk", samp_clk, 1'b0);
        checkOutput("rst_conv_start", conv_start, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_cfg_err", cfg_err, 1'b0);

        rst_b = 1'b1;
        #1;
        checkOutput("release_busy", busy, 1'b0);
        step();
        checkOutput("idle_busy", busy, 1'b0);

        // Continuous run with mid-frame, invalid and pending/overridden loads.
        cur = 0;
        en  = 1'b1;
        while (cur < 85) begin
            case (cur)
                18:      applyStimulus(1'b1, 8'd10, 8'd3);
                43:      applyStimulus(1'b1, 8'd5,  8'd5);
                63:      applyStimulus(1'b1, 8'd6,  8'd2);
                80:      applyStimulus(1'b1, 8'd8,  8'd1);
                81:      applyStimulus(1'b1, 8'd3,  8'd0);
                default: applyStimulus(1'b0, 8'd0,  8'd0);
            endcase
            step();
            checkOutput($sformatf("samp_clk@%0d", cur), samp_clk, exp_samp(cur));
            checkOutput($sformatf("conv_start@%0d", cur), conv_start, exp_conv(cur));
            checkOutput($sformatf("busy@%0d", cur), busy, 1'b1);
            checkOutput($sformatf("cfg_err@%0d", cur), cfg_err,
                        ((cur >= 44 && cur <= 63) || cur >= 82) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset in the middle of a sampling window.
        #2;
        rst_b = 1'b0;
        #1;
        checkOutput("async_samp_clk", samp_clk, 1'b0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_conv_start", conv_start, 1'b0);
        checkOutput("async_cfg_err", cfg_err, 1'b0);
        en = 1'b0;
        step();
        step();
        checkOutput("held_rst_samp_clk", samp_clk, 1'b0);
        rst_b = 1'b1;
        #1;
        checkOutput("release2_busy", busy, 1'b0);

        // en dropped in the second window cycle: default 16/4 frame still completes.
        cur = 0;
        en  = 1'b1;
        while (cur < 20) begin
            if (cur == 2) en = 1'b0;
            step();
            checkOutput($sformatf("drop_samp_clk@%0d", cur), samp_clk,
                        (cur >= 1 && cur <= 4) ? 1'b1 : 1'b0);
            checkOutput($sformatf("drop_conv_start@%0d", cur), conv_start,
                        (cur == 5) ? 1'b1 : 1'b0);
            checkOutput($sformatf("drop_busy@%0d", cur), busy,
                        (cur <= 16) ? 1'b1 : 1'b0);
        end

`ifdef SAMP_BURST_EN
        // Three-frame burst with en held high.
        begin
            int rises = 0;
            int dones = 0;
            logic prev = 1'b0;
            burst_len = 8'd3;
            cur = 0;
            en  = 1'b1;
            while (cur < 70) begin
                step();
                if (samp_clk && !prev) rises++;
                prev = samp_clk;
                if (burst_done) dones++;
                if (cur == 49) checkOutput("burst_done@49", burst_done, 1'b1);
            end
            checkOutput("burst_pulses", (rises == 3), 1'b1);
            checkOutput("burst_done_once", (dones == 1), 1'b1);
            checkOutput("burst_busy_end", busy, 1'b0);
            en = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
